// File: rtl/band_scale_eq_if.sv
// Sample-set bus of the equalizer gain stage: band samples and POTs in,
// scaled bands, their sum and status flags out.
interface band_scale_eq_if #(
  parameter int NUM_BANDS = 5,
  parameter int AUDIO_W   = 16,
  parameter int POT_W     = 12
);
  logic                         vld_in;
  logic [NUM_BANDS*AUDIO_W-1:0] audio_in;
  logic [NUM_BANDS*POT_W-1:0]   pot_in;
  logic                         busy;
  logic                         vld_out;
  logic [NUM_BANDS*AUDIO_W-1:0] scaled_out;
  logic [AUDIO_W-1:0]           sum_out;
  logic                         ovr;

  modport master (
    output vld_in, audio_in, pot_in,
    input  busy, vld_out, scaled_out, sum_out, ovr
  );

  modport slave (
    input  vld_in, audio_in, pot_in,
    output busy, vld_out, scaled_out, sum_out, ovr
  );
endinterface

// File: rtl/band_scale_eq.sv
// band_scale_eq: multi-band gain stage. A single shared multiplier walks the
// bands one per clock, applying a slew-limited squared-POT gain, and produces
// saturated per-band outputs plus their saturated sum.
module band_scale_eq #(
  parameter int NUM_BANDS = 5,
  parameter int AUDIO_W   = 16,
  parameter int POT_W     = 12,
  parameter int SLEW      = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  band_scale_eq_if.slave bus
);

  localparam int CNT_W  = $clog2(NUM_BANDS);
  localparam int ACC_W  = AUDIO_W + $clog2(NUM_BANDS);
  localparam int PROD_W = POT_W + 1 + AUDIO_W;
  localparam int SHIFT  = POT_W - 2;
  localparam int unsigned SLEW_U = SLEW;
  localparam logic [POT_W-1:0] SLEW_V   = POT_W'(SLEW_U);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BANDS - 1);
  localparam logic signed [AUDIO_W-1:0] SAT_MAX = {1'b0, {(AUDIO_W-1){1'b1}}};
  localparam logic signed [AUDIO_W-1:0] SAT_MIN = {1'b1, {(AUDIO_W-1){1'b0}}};

  typedef logic signed [AUDIO_W-1:0] sample_t;
  typedef logic [POT_W-1:0]          pot_t;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  sample_t                 audio_hold_q [NUM_BANDS];
  sample_t                 audio_hold_d [NUM_BANDS];
  pot_t                    pot_hold_q [NUM_BANDS];
  pot_t                    pot_hold_d [NUM_BANDS];
  pot_t                    g_q [NUM_BANDS];
  pot_t                    g_d [NUM_BANDS];
  sample_t                 stage_q [NUM_BANDS];
  sample_t                 stage_d [NUM_BANDS];
  sample_t                 scaled_q [NUM_BANDS];
  sample_t                 scaled_d [NUM_BANDS];
  sample_t                 sum_q, sum_d;
  logic                    vld_out_q, vld_out_d;
  logic                    ovr_q, ovr_d;

  pot_t                    pot_cur, g_cur, target, diff, g_new;
  sample_t                 audio_cur;
  logic [2*POT_W-1:0]      pot_sq;
  logic signed [PROD_W-1:0] g_ext, audio_ext, prod, prod_sh;
  logic [POT_W+1:0]        prod_top;
  sample_t                 scl;
  logic signed [ACC_W-1:0] scl_ext;
  logic [ACC_W-AUDIO_W:0]  acc_top;
  sample_t                 sum_sat;
  logic [NUM_BANDS*AUDIO_W-1:0] scaled_pack;

  // Per-band datapath: slew-limited gain update, then multiply with the new gain and saturate
  always_comb begin
    pot_cur   = pot_hold_q[cnt_q];
    g_cur     = g_q[cnt_q];
    audio_cur = audio_hold_q[cnt_q];
    pot_sq    = {{POT_W{1'b0}}, pot_cur} * {{POT_W{1'b0}}, pot_cur};
    target    = pot_sq[2*POT_W-1:POT_W];
    diff      = (target >= g_cur) ? (target - g_cur) : (g_cur - target);
    if (SLEW_U == 0 || 32'(diff) <= SLEW_U) begin
      g_new = target;
    end else if (target > g_cur) begin
      g_new = g_cur + SLEW_V;
    end else begin
      g_new = g_cur - SLEW_V;
    end
    g_ext     = PROD_W'($signed({1'b0, g_new}));
    audio_ext = PROD_W'(audio_cur);
    prod      = g_ext * audio_ext;
    prod_sh   = prod >>> SHIFT;
    prod_top  = prod_sh[PROD_W-1:AUDIO_W-1];
    if (&prod_top || ~|prod_top) begin
      scl = prod_sh[AUDIO_W-1:0];
    end else if (prod_sh[PROD_W-1]) begin
      scl = SAT_MIN;
    end else begin
      scl = SAT_MAX;
    end
    scl_ext = ACC_W'(scl);
    acc_top = acc_q[ACC_W-1:AUDIO_W-1];
    if (&acc_top || ~|acc_top) begin
      sum_sat = acc_q[AUDIO_W-1:0];
    end else if (acc_q[ACC_W-1]) begin
      sum_sat = SAT_MIN;
    end else begin
      sum_sat = SAT_MAX;
    end
  end

  // Sequencing: capture a set in IDLE, walk the bands in CALC, publish results in FIN
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    audio_hold_d = audio_hold_q;
    pot_hold_d   = pot_hold_q;
    g_d          = g_q;
    stage_d      = stage_q;
    scaled_d     = scaled_q;
    sum_d        = sum_q;
    vld_out_d    = 1'b0;
    ovr_d        = ovr_q;
    case (state_q)
      IDLE: begin
        if (bus.vld_in) begin
          for (int b = 0; b < NUM_BANDS; b++) begin
            audio_hold_d[b] = bus.audio_in[b*AUDIO_W +: AUDIO_W];
            pot_hold_d[b]   = bus.pot_in[b*POT_W +: POT_W];
          end
          cnt_d   = '0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        g_d[cnt_q]     = g_new;
        stage_d[cnt_q] = scl;
        acc_d          = acc_q + scl_ext;
        if (cnt_q == LAST_CNT) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        sum_d     = sum_sat;
        scaled_d  = stage_q;
        vld_out_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.vld_in && state_q != IDLE) begin
      ovr_d = 1'b1;
    end
  end

  // State and datapath registers; reset also clears the smoothing gains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      audio_hold_q <= '{default: '0};
      pot_hold_q   <= '{default: '0};
      g_q          <= '{default: '0};
      stage_q      <= '{default: '0};
      scaled_q     <= '{default: '0};
      sum_q        <= '0;
      vld_out_q    <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      audio_hold_q <= audio_hold_d;
      pot_hold_q   <= pot_hold_d;
      g_q          <= g_d;
      stage_q      <= stage_d;
      scaled_q     <= scaled_d;
      sum_q        <= sum_d;
      vld_out_q    <= vld_out_d;
      ovr_q        <= ovr_d;
    end
  end

  // Pack the per-band results into the output bus layout
  always_comb begin
    scaled_pack = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      scaled_pack[b*AUDIO_W +: AUDIO_W] = scaled_q[b];
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.vld_out    = vld_out_q;
  assign bus.scaled_out = scaled_pack;
  assign bus.sum_out    = sum_q;
  assign bus.ovr        = ovr_q;

endmodule

// File: tb/tb_band_scale_eq.sv
// Testbench for band_scale_eq: one instance without smoothing and one with
// SLEW=64, driven with identical sample sets and compared against an
// arithmetic reference model of the gain stage.
module tb_band_scale_eq;

  localparam int NB = 5;
  localparam int AW = 16;
  localparam int PW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int vcnt [2] = '{0, 0};
  int gm [2][NB];
  int exp_scl [2][NB];
  int exp_sum [2];

  band_scale_eq_if #(.NUM_BANDS(NB), .AUDIO_W(AW), .POT_W(PW)) if0 ();
  band_scale_eq_if #(.NUM_BANDS(NB), .AUDIO_W(AW), .POT_W(PW)) if1 ();

  band_scale_eq #(.NUM_BANDS(NB), .AUDIO_W(AW), .POT_W(PW), .SLEW(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  band_scale_eq #(.NUM_BANDS(NB), .AUDIO_W(AW), .POT_W(PW), .SLEW(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  always #5 clk = ~clk;

  // Count output strobes of each instance, sampled mid-cycle
  always @(negedge clk) begin
    if (if0.vld_out === 1'b1) vcnt[0]++;
    if (if1.vld_out === 1'b1) vcnt[1]++;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference model: gain chases (pot^2)/2^PW by at most SLEW, output = gain*audio/1024 floored, clamped
  task automatic modelSet(input logic [NB*AW-1:0] a, input logic [NB*PW-1:0] p);
    int slew, total, pot, tgt, g, au, s;
    for (int m = 0; m < 2; m++) begin
      slew  = (m == 0) ? 0 : 64;
      total = 0;
      for (int b = 0; b < NB; b++) begin
        pot = int'(p[b*PW +: PW]);
        tgt = (pot * pot) / 4096;
        g   = gm[m][b];
        if (slew == 0 || (tgt - g <= slew && g - tgt <= slew)) g = tgt;
        else if (tgt > g) g = g + slew;
        else g = g - slew;
        gm[m][b] = g;
        au = int'($signed(a[b*AW +: AW]));
        s  = clamp16((g * au) >>> 10);
        exp_scl[m][b] = s;
        total += s;
      end
      exp_sum[m] = clamp16(total);
    end
  endtask

  task automatic clearModel();
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < NB; b++) begin
        gm[m][b] = 0;
        exp_scl[m][b] = 0;
      end
      exp_sum[m] = 0;
    end
  endtask

  function automatic logic [NB*AW-1:0] fillAudio(input logic [AW-1:0] v);
    logic [NB*AW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*AW +: AW] = v;
    return r;
  endfunction

  function automatic logic [NB*PW-1:0] fillPot(input logic [PW-1:0] v);
    logic [NB*PW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*PW +: PW] = v;
    return r;
  endfunction

  // Called just after a falling edge: present a set for one cycle
  task automatic driveSet(input logic [NB*AW-1:0] a, input logic [NB*PW-1:0] p);
    if0.audio_in = a; if0.pot_in = p; if0.vld_in = 1'b1;
    if1.audio_in = a; if1.pot_in = p; if1.vld_in = 1'b1;
    @(negedge clk);
    if0.vld_in = 1'b0;
    if1.vld_in = 1'b0;
  endtask

  task automatic applyStimulus(input logic [NB*AW-1:0] a, input logic [NB*PW-1:0] p);
    modelSet(a, p);
    driveSet(a, p);
    checkValue("busy after accept", 32'(if0.busy), 32'd1);
  endtask

  task automatic waitResult(input string tag);
    int cyc;
    cyc = 0;
    for (int i = 1; i <= 20 && cyc == 0; i++) begin
      @(negedge clk);
      if (if0.vld_out === 1'b1) cyc = i;
    end
    checkValue({tag, " latency"}, 32'(cyc), 32'd6);
    checkValue({tag, " busy in vld_out cycle"}, 32'(if0.busy), 32'd0);
    checkValue({tag, " dut1 vld_out"}, 32'(if1.vld_out), 32'd1);
  endtask

  task automatic checkOutput(input int m, input string tag);
    logic [NB*AW-1:0] so;
    logic [AW-1:0]    sm, e;
    so = (m == 0) ? if0.scaled_out : if1.scaled_out;
    sm = (m == 0) ? if0.sum_out : if1.sum_out;
    for (int b = 0; b < NB; b++) begin
      e = AW'(exp_scl[m][b]);
      checkValue($sformatf("%s dut%0d band%0d", tag, m, b), 32'(so[b*AW +: AW]), 32'(e));
    end
    e = AW'(exp_sum[m]);
    checkValue($sformatf("%s dut%0d sum", tag, m), 32'(sm), 32'(e));
  endtask

  task automatic runSet(input logic [NB*AW-1:0] a, input logic [NB*PW-1:0] p, input string tag);
    applyStimulus(a, p);
    waitResult(tag);
    checkOutput(0, tag);
    checkOutput(1, tag);
  endtask

  task automatic checkIdleZero(input string tag);
    clearModel();
    checkValue({tag, " busy0"}, 32'(if0.busy), 32'd0);
    checkValue({tag, " busy1"}, 32'(if1.busy), 32'd0);
    checkValue({tag, " vld0"}, 32'(if0.vld_out), 32'd0);
    checkValue({tag, " vld1"}, 32'(if1.vld_out), 32'd0);
    checkValue({tag, " ovr0"}, 32'(if0.ovr), 32'd0);
    checkValue({tag, " ovr1"}, 32'(if1.ovr), 32'd0);
    checkOutput(0, tag);
    checkOutput(1, tag);
  endtask

  initial begin
    logic [NB*AW-1:0] a;
    logic [NB*PW-1:0] p;
    int vbase, seen, expv;

    if0.vld_in = 1'b0; if0.audio_in = '0; if0.pot_in = '0;
    if1.vld_in = 1'b0; if1.audio_in = '0; if1.pot_in = '0;
    clearModel();
    $display("[TB] start");

    // Reset state, and a strobe while reset is held must not produce output
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleZero("T1 reset");
    driveSet(fillAudio(16'h1000), fillPot(12'h800));
    repeat (10) @(negedge clk);
    checkValue("T1 no vld_out in reset", 32'(vcnt[0] + vcnt[1]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsmoothed gain points: unity, near-max gain saturation, negative saturation, zero
    a = {16'hF000, 16'h7FFF, 16'h8000, 16'h4000, 16'h1234};
    p = {12'h800, 12'h000, 12'hFFF, 12'hFFF, 12'h800};
    runSet(a, p, "T2");
    checkValue("T2 unity band0", 32'(if0.scaled_out[15:0]), 32'h1234);
    checkValue("T2 pos sat band1", 32'(if0.scaled_out[31:16]), 32'h7FFF);
    checkValue("T2 neg sat band2", 32'(if0.scaled_out[47:32]), 32'h8000);
    checkValue("T2 zero pot band3", 32'(if0.scaled_out[63:48]), 32'h0000);

    // Slew ramp from cleared gains
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    clearModel();
    for (int k = 1; k <= 18; k++) begin
      runSet(fillAudio(16'h1000), fillPot(12'h800), "T3 up");
      expv = ((k < 16) ? k : 16) * 256;
      checkValue($sformatf("T3 ramp set%0d", k), 32'(if1.scaled_out[15:0]), 32'(expv));
      checkValue($sformatf("T3 noslew set%0d", k), 32'(if0.scaled_out[15:0]), 32'h1000);
    end
    for (int k = 1; k <= 3; k++) begin
      runSet(fillAudio(16'h1000), fillPot(12'h000), "T3 down");
      expv = 4096 - k * 256;
      checkValue($sformatf("T3 ramp down set%0d", k), 32'(if1.scaled_out[15:0]), 32'(expv));
    end

    // Sum saturation and mixed-sign sums
    runSet(fillAudio(16'h2000), fillPot(12'h800), "T4 a");
    checkValue("T4 sum pos sat", 32'(if0.sum_out), 32'h7FFF);
    runSet({16'h0000, 16'h0000, 16'h0100, 16'hF000, 16'h1000}, fillPot(12'h800), "T4 b");
    checkValue("T4 sum mixed", 32'(if0.sum_out), 32'h0100);
    runSet(fillAudio(16'hC000), fillPot(12'h800), "T4 c");
    checkValue("T4 sum neg sat", 32'(if0.sum_out), 32'h8000);
    checkValue("ovr still clear", 32'(if0.ovr), 32'd0);

    // Overrun: second strobe two clocks after the first is dropped
    repeat (3) @(negedge clk);
    vbase = vcnt[0];
    a = {16'h0123, 16'hFEDC, 16'h0700, 16'h8001, 16'h3000};
    p = {12'h400, 12'hA00, 12'h800, 12'h7FF, 12'hC00};
    modelSet(a, p);
    driveSet(a, p);
    @(negedge clk);
    driveSet(fillAudio(16'h7FFF), fillPot(12'hFFF));
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (if0.vld_out === 1'b1) seen = 1;
    end
    checkValue("T5 first set vld_out", 32'(seen), 32'd1);
    checkOutput(0, "T5 overrun");
    checkOutput(1, "T5 overrun");
    checkValue("T5 ovr0", 32'(if0.ovr), 32'd1);
    checkValue("T5 ovr1", 32'(if1.ovr), 32'd1);
    runSet(fillAudio(16'h0800), fillPot(12'h900), "T5 b2b");
    repeat (8) @(negedge clk);
    checkValue("T5 vld_out count", 32'(vcnt[0] - vbase), 32'd2);

    // Reset while band 2 is being processed
    driveSet(fillAudio(16'h1000), fillPot(12'h800));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vbase = vcnt[0] + vcnt[1];
    checkIdleZero("T6 mid reset");
    repeat (10) @(negedge clk);
    checkValue("T6 no vld_out", 32'(vcnt[0] + vcnt[1]), 32'(vbase));
    runSet(fillAudio(16'h1000), fillPot(12'h800), "T6 restart");
    checkValue("T6 ramp restarts", 32'(if1.scaled_out[15:0]), 32'h0100);

    // Randomised sets against the model
    for (int n = 0; n < 40; n++) begin
      for (int b = 0; b < NB; b++) begin
        a[b*AW +: AW] = AW'($urandom());
        case ($urandom_range(0, 4))
          0: p[b*PW +: PW] = 12'h000;
          1: p[b*PW +: PW] = 12'hFFF;
          2: p[b*PW +: PW] = 12'h800;
          default: p[b*PW +: PW] = PW'($urandom());
        endcase
      end
      runSet(a, p, $sformatf("RND%0d", n));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
